// File: rtl/fp_pipeline_scheduler.sv
// Issue scheduler and in-flight tracker for the shared non-stallable FP adder; one grant per cycle, result tagged at the tail.
// Latency: request -> issue_valid_o 1 cycle, issue -> wb_valid_o FP_LATENCY cycles; no backpressure (wb_claim_i only blocks issue).
// Build option FP_SCHED_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest eligible index wins.
module fp_pipeline_scheduler #(
  parameter int NUM_STRANDS     = 4,
  parameter int STRAND_ID_WIDTH = 2,
  parameter int FP_LATENCY      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_STRANDS-1:0]       request_i,
  input  logic [6*NUM_STRANDS-1:0]     operation_i,
  input  logic                         wb_claim_i,
  input  logic                         rollback_i,
  input  logic [STRAND_ID_WIDTH-1:0]   rollback_strand_i,
  output logic [NUM_STRANDS-1:0]       grant_o,
  output logic                         issue_valid_o,
  output logic [5:0]                   issue_op_o,
  output logic [STRAND_ID_WIDTH-1:0]   issue_strand_o,
  output logic                         wb_valid_o,
  output logic [STRAND_ID_WIDTH-1:0]   wb_strand_o,
  output logic [NUM_STRANDS-1:0]       inflight_o
);

  logic [NUM_STRANDS-1:0]     inflight;
  logic [NUM_STRANDS-1:0]     eligible;
  logic [NUM_STRANDS-1:0]     grant_nxt;
  logic [NUM_STRANDS-1:0]     wb_clr;
  logic [NUM_STRANDS-1:0]     rb_clr;
  logic                       grant_any;
  logic [STRAND_ID_WIDTH-1:0] grant_idx;
  logic [5:0]                 op_nxt;
  logic [FP_LATENCY-1:0]      trk_vld;
  logic [STRAND_ID_WIDTH-1:0] trk_strand [FP_LATENCY];

  always_comb begin
    eligible = '0;
    wb_clr   = '0;
    rb_clr   = '0;
    for (int s = 0; s < NUM_STRANDS; s++) begin
      rb_clr[s]   = rollback_i && (rollback_strand_i == STRAND_ID_WIDTH'(s));
      wb_clr[s]   = wb_valid_o && (wb_strand_o == STRAND_ID_WIDTH'(s));
      eligible[s] = request_i[s] && !inflight[s] && !rb_clr[s] && !wb_claim_i;
    end
  end

`ifdef FP_SCHED_ROUND_ROBIN_EN
  logic [STRAND_ID_WIDTH-1:0] rr_ptr;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_STRANDS; k++) begin
      if (!grant_any && eligible[(int'(rr_ptr) + k) % NUM_STRANDS]) begin
        grant_any = 1'b1;
        grant_idx = STRAND_ID_WIDTH'((int'(rr_ptr) + k) % NUM_STRANDS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(grant_idx) == NUM_STRANDS - 1) ? '0 : grant_idx + STRAND_ID_WIDTH'(1);
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_STRANDS; k++) begin
      if (!grant_any && eligible[k]) begin
        grant_any = 1'b1;
        grant_idx = STRAND_ID_WIDTH'(k);
      end
    end
  end
`endif

  always_comb begin
    grant_nxt = '0;
    op_nxt    = '0;
    for (int s = 0; s < NUM_STRANDS; s++) begin
      grant_nxt[s] = grant_any && (grant_idx == STRAND_ID_WIDTH'(s));
      if (grant_nxt[s]) op_nxt = operation_i[6*s +: 6];
    end
  end

  // A grant can never target a strand being cleared, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_o        <= '0;
      issue_valid_o  <= 1'b0;
      issue_op_o     <= '0;
      issue_strand_o <= '0;
      inflight       <= '0;
    end else begin
      grant_o        <= grant_nxt;
      issue_valid_o  <= grant_any;
      issue_op_o     <= op_nxt;
      issue_strand_o <= grant_idx;
      inflight       <= (inflight & ~wb_clr & ~rb_clr) | grant_nxt;
    end
  end

  // Rollback squashes matching entries as they shift; the tail itself is already committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_vld <= '0;
      for (int i = 0; i < FP_LATENCY; i++) trk_strand[i] <= '0;
    end else begin
      trk_vld[0]    <= issue_valid_o && !(rollback_i && issue_strand_o == rollback_strand_i);
      trk_strand[0] <= issue_strand_o;
      for (int i = 1; i < FP_LATENCY; i++) begin
        trk_vld[i]    <= trk_vld[i-1] && !(rollback_i && trk_strand[i-1] == rollback_strand_i);
        trk_strand[i] <= trk_strand[i-1];
      end
    end
  end

  assign wb_valid_o  = trk_vld[FP_LATENCY-1];
  assign wb_strand_o = trk_strand[FP_LATENCY-1];
  assign inflight_o  = inflight;

endmodule

// File: tb/tb_fp_pipeline_scheduler.sv
// Bench for fp_pipeline_scheduler: directed scenarios plus random traffic against a
// pending-writeback list model (each issued op carries its due cycle).
module tb_fp_pipeline_scheduler;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int L  = 4;
  localparam logic [5:0] OP_FADD = 6'h01;
  localparam logic [5:0] OP_FSUB = 6'h02;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    request_i = '0;
  logic [6*N-1:0]  operation_i = '0;
  logic            wb_claim_i = 1'b0;
  logic            rollback_i = 1'b0;
  logic [SW-1:0]   rollback_strand_i = '0;
  logic [N-1:0]    grant_o;
  logic            issue_valid_o;
  logic [5:0]      issue_op_o;
  logic [SW-1:0]   issue_strand_o;
  logic            wb_valid_o;
  logic [SW-1:0]   wb_strand_o;
  logic [N-1:0]    inflight_o;

  fp_pipeline_scheduler #(.NUM_STRANDS(N), .STRAND_ID_WIDTH(SW), .FP_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .request_i(request_i), .operation_i(operation_i),
    .wb_claim_i(wb_claim_i), .rollback_i(rollback_i), .rollback_strand_i(rollback_strand_i),
    .grant_o(grant_o), .issue_valid_o(issue_valid_o), .issue_op_o(issue_op_o),
    .issue_strand_o(issue_strand_o), .wb_valid_o(wb_valid_o), .wb_strand_o(wb_strand_o),
    .inflight_o(inflight_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {int strand; int due;} pend_t;
  pend_t        pend[$];
  bit [N-1:0]   m_inflight;
  int           m_rr;
  bit           e_vld;
  bit [N-1:0]   e_grant;
  bit [5:0]     e_op;
  int           e_strand;
  int           cyc;
  int           obs_wb[N];

  task automatic model_reset();
    pend.delete();
    m_inflight = '0;
    m_rr = 0;
    e_vld = 1'b0;
    e_grant = '0;
    e_op = '0;
    e_strand = 0;
  endtask

  task automatic cycle(input bit [N-1:0] req, input bit [6*N-1:0] ops, input bit claim,
                       input bit rb, input int rbs, input bit rst);
    int    wb_k;
    int    g;
    pend_t keep[$];
    @(negedge clk);
    check("issue_valid", issue_valid_o, e_vld);
    check("grant", grant_o, e_grant);
    check("issue_op", issue_op_o, e_op);
    if (e_vld) check("issue_strand", issue_strand_o, e_strand);
    wb_k = -1;
    foreach (pend[k]) if (pend[k].due == cyc) wb_k = k;
    check("wb_valid", wb_valid_o, (wb_k >= 0));
    if (wb_k >= 0) check("wb_strand", wb_strand_o, pend[wb_k].strand);
    check("inflight", inflight_o, m_inflight);
    if (wb_valid_o) obs_wb[wb_strand_o]++;

    request_i = req;
    operation_i = ops;
    wb_claim_i = claim;
    rollback_i = rb;
    rollback_strand_i = SW'(rbs);
    reset = rst;

    if (rst) begin
      model_reset();
    end else begin
      if (e_vld && !(rb && e_strand == rbs)) pend.push_back('{e_strand, cyc + L});
      if (wb_k >= 0) m_inflight[pend[wb_k].strand] = 1'b0;
      foreach (pend[k]) if (pend[k].due > cyc && !(rb && pend[k].strand == rbs)) keep.push_back(pend[k]);
      pend = keep;
      if (rb) m_inflight[rbs] = 1'b0;
      g = -1;
      if (!claim) begin
        for (int k = 0; k < N; k++) begin
`ifdef FP_SCHED_ROUND_ROBIN_EN
          int s = (m_rr + k) % N;
`else
          int s = k;
`endif
          if (g < 0 && req[s] && !inflight_o[s] && !(rb && rbs == s)) g = s;
        end
      end
      e_vld = (g >= 0);
      e_grant = '0;
      e_op = '0;
      if (g >= 0) begin
        e_grant[g] = 1'b1;
        e_op = ops[6*g +: 6];
        e_strand = g;
        m_inflight[g] = 1'b1;
        m_rr = (g + 1) % N;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic clear_obs();
    for (int s = 0; s < N; s++) obs_wb[s] = 0;
  endtask

  initial begin
    bit [6*N-1:0] ops_all;
    ops_all = {OP_FSUB, OP_FADD, OP_FSUB, OP_FADD};
    cyc = 0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);

    // single FADD on strand 0
    cycle(4'b0001, {18'd0, OP_FADD}, 1'b0, 1'b0, 0, 1'b0);
    idle(L + 3);
    check("single_wb_count", obs_wb[0], 1);

    // all strands requesting
    for (int i = 0; i < 8; i++) cycle(4'b1111, ops_all, 1'b0, 1'b0, 0, 1'b0);
    idle(L + 3);

    // writeback claim on first cycle
    cycle(4'b1010, ops_all, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b1010, ops_all, 1'b0, 1'b0, 0, 1'b0);
    idle(L + 3);

    // strands 0 and 2 back to back, then squash strand 2
    clear_obs();
    cycle(4'b0001, ops_all, 1'b0, 1'b0, 0, 1'b0);
    cycle(4'b0100, ops_all, 1'b0, 1'b0, 0, 1'b0);
    idle(1);
    cycle('0, '0, 1'b0, 1'b1, 2, 1'b0);
    idle(L + 3);
    check("rb_wb_strand0", obs_wb[0], 1);
    check("rb_wb_strand2", obs_wb[2], 0);

    // rollback coincident with request from the same strand
    cycle(4'b0010, ops_all, 1'b0, 1'b1, 1, 1'b0);
    idle(2);

    // reset with three ops in flight
    clear_obs();
    for (int i = 0; i < 3; i++) cycle(4'b0111, ops_all, 1'b0, 1'b0, 0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 0, 1'b1);
    idle(2 * L + 1);
    check("post_reset_wb", obs_wb[0] + obs_wb[1] + obs_wb[2], 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), (6*N)'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0), $urandom_range(0, N - 1),
            ($urandom_range(0, 99) == 0));
    end
    idle(L + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
